// File: rtl/gg_my_ip_pkg.sv
// Shared definitions for the gg_my_IP BIST slice.
// Contents: BIST FSM state encoding, 16-bit Fibonacci LFSR tap mask,
// default seed, and LFSR helper functions used by gg_lfsr16.
package gg_my_ip_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   localparam int          LFSR_W            = 16;
   // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // One Fibonacci step: shift left, XOR of tapped bits enters bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      lfsr_step = {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

   // An all-zero seed would lock the LFSR, so it is swapped for the default.
   function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
      lfsr_seed_fix = (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
   endfunction

endpackage

// File: rtl/gg_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance enable.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (state -> default seed)
//   load   in   load seed this cycle (has priority over enable)
//   enable in   advance one step this cycle
//   seed   in   16-bit seed; zero is replaced by the default seed
//   state  out  current LFSR state
module gg_lfsr16
   import gg_my_ip_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              enable,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_r;

   // LFSR state register: load wins over advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= LFSR_DEFAULT_SEED;
      end else if (load) begin
         state_r <= lfsr_seed_fix(seed);
      end else if (enable) begin
         state_r <= lfsr_step(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/gg_my_ip_bist.sv
// Stimulus generator and response checker for gg_my_IP (adder/multiplier).
// Issues LFSR-derived a/b pairs, delays the expected sum/product through a
// LATENCY-deep pipe, compares against the DUT outputs and reports a result.
// The operand source is a 16-bit LFSR, so WIDTH is expected to be 8.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start                 1-cycle pulse; accepted only in IDLE or DONE
//   num_vectors, seed     run length and LFSR seed, sampled on accepted start
//   dut_a, dut_b, dut_vld stimulus to the DUT (held when dut_vld=0)
//   dut_sum, dut_prod     DUT responses
//   busy, done, pass      run status; pass is valid while done=1
//   err_count, first_fail mismatch count (saturating), first failing index
module gg_my_ip_bist
   import gg_my_ip_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_vectors,
   input  logic [2*WIDTH-1:0]   seed,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   output logic                 dut_vld,
   input  logic [WIDTH:0]       dut_sum,
   input  logic [2*WIDTH-1:0]   dut_prod,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     first_fail
);

   localparam int               DRAIN_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONES   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

   bist_state_t          state_r, state_nx_s;
   logic                 accept_s, issue_s, done_entry_s;
   logic [CNT_W-1:0]     num_r, issued_r;
   logic [DRAIN_W-1:0]   drain_cnt_r;
   logic [2*WIDTH-1:0]   lfsr_s;
   logic [WIDTH-1:0]     dut_a_r, dut_b_r;
   logic                 dut_vld_r;
   logic [CNT_W-1:0]     dut_idx_r;
   logic [WIDTH:0]       exp_sum_s;
   logic [2*WIDTH-1:0]   exp_prod_s;
   logic                 mismatch_s;
   logic [CNT_W-1:0]     err_r, err_nx_s, ff_r, ff_nx_s;
   logic                 busy_r, done_r, pass_r;

   gg_lfsr16 u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .load   (accept_s),
      .enable (issue_s),
      .seed   (seed),
      .state  (lfsr_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state and per-cycle strobes.
   always_comb begin
      state_nx_s   = state_r;
      accept_s     = 1'b0;
      issue_s      = 1'b0;
      done_entry_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               accept_s = 1'b1;
               if (num_vectors == CNT_ZERO) begin
                  state_nx_s   = ST_DONE;
                  done_entry_s = 1'b1;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_RUN: begin
            if (issued_r == num_r) begin
               state_nx_s = ST_DRAIN;
            end else begin
               issue_s    = 1'b1;
               state_nx_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Last vector's response arrives exactly LATENCY edges into DRAIN.
            if (drain_cnt_r == DRAIN_LAST) begin
               state_nx_s   = ST_DONE;
               done_entry_s = 1'b1;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Run length capture, issue counter and drain counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_r       <= CNT_ZERO;
         issued_r    <= CNT_ZERO;
         drain_cnt_r <= {DRAIN_W{1'b0}};
      end else begin
         if (accept_s) begin
            num_r    <= num_vectors;
            issued_r <= CNT_ZERO;
         end else if (issue_s) begin
            num_r    <= num_r;
            issued_r <= issued_r + CNT_W'(1);
         end else begin
            num_r    <= num_r;
            issued_r <= issued_r;
         end
         if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
         end else begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
         end
      end
   end

   // Stimulus registers: operands hold their value between vectors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dut_a_r   <= {WIDTH{1'b0}};
         dut_b_r   <= {WIDTH{1'b0}};
         dut_vld_r <= 1'b0;
         dut_idx_r <= CNT_ZERO;
      end else if (issue_s) begin
         dut_a_r   <= lfsr_s[2*WIDTH-1:WIDTH];
         dut_b_r   <= lfsr_s[WIDTH-1:0];
         dut_vld_r <= 1'b1;
         dut_idx_r <= issued_r;
      end else begin
         dut_a_r   <= dut_a_r;
         dut_b_r   <= dut_b_r;
         dut_vld_r <= 1'b0;
         dut_idx_r <= dut_idx_r;
      end
   end

   // Expectations are formed from the registered operands, i.e. from what
   // the DUT actually sees, so the pipe aligns with the DUT's output edge.
   assign exp_sum_s  = {1'b0, dut_a_r} + {1'b0, dut_b_r};
   assign exp_prod_s = {{WIDTH{1'b0}}, dut_a_r} * {{WIDTH{1'b0}}, dut_b_r};

   for (genvar i = 0; i < LATENCY; i++) begin : g_pipe
      logic                 vld_r, in_vld_s;
      logic [WIDTH:0]       sum_r, in_sum_s;
      logic [2*WIDTH-1:0]   prod_r, in_prod_s;
      logic [CNT_W-1:0]     idx_r, in_idx_s;

      if (i == 0) begin : g_head
         assign in_vld_s  = dut_vld_r;
         assign in_sum_s  = exp_sum_s;
         assign in_prod_s = exp_prod_s;
         assign in_idx_s  = dut_idx_r;
      end else begin : g_tail
         assign in_vld_s  = g_pipe[i-1].vld_r;
         assign in_sum_s  = g_pipe[i-1].sum_r;
         assign in_prod_s = g_pipe[i-1].prod_r;
         assign in_idx_s  = g_pipe[i-1].idx_r;
      end

      // One expectation pipe stage.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_r  <= 1'b0;
            sum_r  <= {(WIDTH+1){1'b0}};
            prod_r <= {(2*WIDTH){1'b0}};
            idx_r  <= CNT_ZERO;
         end else begin
            vld_r  <= in_vld_s;
            sum_r  <= in_sum_s;
            prod_r <= in_prod_s;
            idx_r  <= in_idx_s;
         end
      end
   end

   // Compare pipe head against DUT and form next error/first-fail values.
   always_comb begin
      mismatch_s = 1'b0;
      err_nx_s   = err_r;
      ff_nx_s    = ff_r;
      if (g_pipe[LATENCY-1].vld_r) begin
         mismatch_s = (dut_sum != g_pipe[LATENCY-1].sum_r) ||
                      (dut_prod != g_pipe[LATENCY-1].prod_r);
      end else begin
         mismatch_s = 1'b0;
      end
      if (mismatch_s && (err_r != CNT_ONES)) begin
         err_nx_s = err_r + CNT_W'(1);
      end else begin
         err_nx_s = err_r;
      end
      if (mismatch_s && (ff_r == CNT_ONES)) begin
         ff_nx_s = g_pipe[LATENCY-1].idx_r;
      end else begin
         ff_nx_s = ff_r;
      end
   end

   // Result registers; pass includes a compare landing on the DONE edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r  <= CNT_ZERO;
         ff_r   <= CNT_ONES;
         pass_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         if (accept_s) begin
            err_r  <= CNT_ZERO;
            ff_r   <= CNT_ONES;
            pass_r <= done_entry_s;
         end else if (done_entry_s) begin
            err_r  <= err_nx_s;
            ff_r   <= ff_nx_s;
            pass_r <= (err_nx_s == CNT_ZERO);
         end else begin
            err_r  <= err_nx_s;
            ff_r   <= ff_nx_s;
            pass_r <= pass_r;
         end
         busy_r <= (state_nx_s == ST_RUN) || (state_nx_s == ST_DRAIN);
         done_r <= (state_nx_s == ST_DONE);
      end
   end

   assign dut_a      = dut_a_r;
   assign dut_b      = dut_b_r;
   assign dut_vld    = dut_vld_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign err_count  = err_r;
   assign first_fail = ff_r;

endmodule
